// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/done request bus between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1_data, rs2_data, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add / restoring) on operand magnitudes.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              s1_q, s1_d, s2_q, s2_d;
    logic [XLEN:0]     hi_q, hi_d, mc_q, mc_d;
    logic [XLEN-1:0]   lo_q, lo_d, res_q, res_d;

    logic              sg1, sg2, n1, n2, dz, ov, ge, accept;
    logic [XLEN:0]     m1, m2, add, sh, sub;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fast_res, fix_res;

    always_comb begin
        sg1      = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'd1 || bus.op[1:0] == 2'd2);
        sg2      = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'd1);
        n1       = sg1 & bus.rs1_data[XLEN-1];
        n2       = sg2 & bus.rs2_data[XLEN-1];
        // Negating the sign-extended value keeps the most negative operand exact.
        m1       = n1 ? -{1'b1, bus.rs1_data} : {1'b0, bus.rs1_data};
        m2       = n2 ? -{1'b1, bus.rs2_data} : {1'b0, bus.rs2_data};
        dz       = bus.op[2] & (bus.rs2_data == '0);
        ov       = bus.op[2] & ~bus.op[0] & (bus.rs1_data == MIN) & (&bus.rs2_data);
        fast_res = dz ? (bus.op[1] ? bus.rs1_data : '1) : (bus.op[1] ? '0 : bus.rs1_data);
        add      = hi_q + (lo_q[0] ? mc_q : '0);
        sh       = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        ge       = sh >= mc_q;
        sub      = sh - mc_q;
        prod     = (s1_q ^ s2_q) ? -{hi_q[XLEN-1:0], lo_q} : {hi_q[XLEN-1:0], lo_q};
        quo      = (s1_q ^ s2_q) ? -lo_q : lo_q;
        rem      = s1_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
        fix_res  = op_q[2] ? (op_q[1] ? rem : quo)
                           : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        accept   = bus.start & ~bus.flush & (state_q == IDLE || state_q == DONE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        hi_d    = hi_q;
        mc_d    = mc_q;
        lo_d    = lo_q;
        res_d   = res_q;
        if (accept) begin
            op_d    = bus.op;
            s1_d    = n1;
            s2_d    = n2;
            cnt_d   = '0;
            hi_d    = '0;
            mc_d    = bus.op[2] ? m2 : m1;
            lo_d    = bus.op[2] ? m1[XLEN-1:0] : m2[XLEN-1:0];
            state_d = (dz | ov) ? DONE : CALC;
            res_d   = (dz | ov) ? fast_res : res_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if ((state_q == CALC || state_q == FIX) && bus.flush) begin
            state_d = IDLE;
        end else if (state_q == CALC) begin
            // hi_q holds the running partial product or partial remainder.
            cnt_d   = cnt_q + 1'b1;
            hi_d    = op_q[2] ? (ge ? sub : sh) : {1'b0, add[XLEN:1]};
            lo_d    = op_q[2] ? {lo_q[XLEN-2:0], ge} : {add[0], lo_q[XLEN-1:1]};
            state_d = (cnt_q == CNT_W'(XLEN - 1)) ? FIX : CALC;
        end else if (state_q == FIX) begin
            res_d   = fix_res;
            state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            hi_q    <= '0;
            mc_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            hi_q    <= hi_d;
            mc_q    <= mc_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy   = (state_q == CALC) || (state_q == FIX);
    assign bus.done   = (state_q == DONE);
    assign bus.result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for 32-bit and 8-bit muldiv_unit instances.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] res;
        int          t0;
        int          lat;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    exp_t q32[$];
    exp_t q8[$];

    muldiv_unit_if #(.XLEN(32)) b32 ();
    muldiv_unit_if #(.XLEN(8))  b8 ();

    muldiv_unit #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
    muldiv_unit #(.XLEN(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec_t v32 [0:18] = '{
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34},
        '{3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 34},
        '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 34},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34},
        '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34},
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34},
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34},
        '{3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 34},
        '{3'd7, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 34},
        '{3'd4, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 34},
        '{3'd6, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 34},
        '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34},
        '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34},
        '{3'd4, 32'h0000DEAD, 32'h00000000, 32'hFFFFFFFF, 1},
        '{3'd6, 32'h00001234, 32'h00000000, 32'h00001234, 1},
        '{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1},
        '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1}
    };

    vec_t v8 [0:9] = '{
        '{3'd0, 32'h0F, 32'h11, 32'hFF, 10},
        '{3'd1, 32'h80, 32'h80, 32'h40, 10},
        '{3'd2, 32'h80, 32'h80, 32'hC0, 10},
        '{3'd4, 32'hF9, 32'h02, 32'hFD, 10},
        '{3'd6, 32'hF9, 32'h02, 32'hFF, 10},
        '{3'd5, 32'hF9, 32'h02, 32'h7C, 10},
        '{3'd4, 32'h12, 32'h00, 32'hFF, 1},
        '{3'd6, 32'h12, 32'h00, 32'h12, 1},
        '{3'd4, 32'h80, 32'hFF, 32'h80, 1},
        '{3'd6, 32'h80, 32'hFF, 32'h00, 1}
    };

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic go32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int lat, input string n);
        @(negedge clk);
        b32.start = 1'b1;
        b32.op = op;
        b32.rs1_data = a;
        b32.rs2_data = b;
        if (lat > 0) q32.push_back('{res: r, t0: cyc, lat: lat, name: n});
        @(negedge clk);
        b32.start = 1'b0;
    endtask

    task automatic go8(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat, input string n);
        @(negedge clk);
        b8.start = 1'b1;
        b8.op = op;
        b8.rs1_data = a[7:0];
        b8.rs2_data = b[7:0];
        if (lat > 0) q8.push_back('{res: r, t0: cyc, lat: lat, name: n});
        @(negedge clk);
        b8.start = 1'b0;
    endtask

    task automatic drain(input string n);
        for (int i = 0; i < 200; i++) begin
            if (q32.size() == 0 && q8.size() == 0) break;
            @(negedge clk);
        end
        chk(n, q32.size() + q8.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && b32.done) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done32 result=%h", b32.result);
                end else begin
                    e = q32.pop_front();
                    if (b32.result !== e.res || cyc - e.t0 != e.lat) begin
                        errors++;
                        $display("FAIL %s result=%h want=%h latency=%0d want=%0d",
                                 e.name, b32.result, e.res, cyc - e.t0, e.lat);
                    end
                end
            end
            if (!rst && b8.done) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done8 result=%h", b8.result);
                end else begin
                    e = q8.pop_front();
                    if ({24'h0, b8.result} !== e.res || cyc - e.t0 != e.lat) begin
                        errors++;
                        $display("FAIL %s result=%h want=%h latency=%0d want=%0d",
                                 e.name, b8.result, e.res, cyc - e.t0, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        int bc;
        bit seen;
        b32.start = 1'b0; b32.flush = 1'b0; b32.op = '0; b32.rs1_data = '0; b32.rs2_data = '0;
        b8.start = 1'b0;  b8.flush = 1'b0;  b8.op = '0;  b8.rs1_data = '0;  b8.rs2_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy32", b32.busy, 0);
        chk("rst_done32", b32.done, 0);
        chk("rst_result32", b32.result, 0);
        chk("rst_result8", {24'h0, b8.result}, 0);
        rst = 1'b0;

        @(negedge clk);
        b32.start = 1'b1; b32.op = 3'd0; b32.rs1_data = 32'h7; b32.rs2_data = 32'hFFFFFFFD;
        q32.push_back('{res: 32'hFFFFFFEB, t0: cyc, lat: 34, name: "mul_7_m3"});
        bc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            b32.start = 1'b0;
            if (b32.busy) bc++;
            if (b32.done) break;
        end
        chk("mul_busy_cycles", bc, 33);
        @(negedge clk);
        chk("done_width", b32.done, 0);
        drain("drain_mul");

        foreach (v32[i]) begin
            go32(v32[i].op, v32[i].a, v32[i].b, v32[i].r, v32[i].lat, $sformatf("v32_%0d", i));
            drain($sformatf("drain_v32_%0d", i));
        end

        go32(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "start_in_calc");
        repeat (5) @(negedge clk);
        b32.start = 1'b1; b32.op = 3'd4; b32.rs1_data = 32'h1; b32.rs2_data = 32'h0;
        @(negedge clk);
        b32.start = 1'b0;
        drain("drain_start_in_calc");
        repeat (40) @(negedge clk);

        go32(3'd5, 32'h64, 32'h7, 32'h0, 0, "flushed");
        repeat (9) @(negedge clk);
        b32.flush = 1'b1;
        @(negedge clk);
        b32.flush = 1'b0;
        chk("flush_busy", b32.busy, 0);
        chk("flush_result", b32.result, 32'hFFFFFFFE);
        repeat (40) @(negedge clk);
        chk("flush_result_held", b32.result, 32'hFFFFFFFE);

        go32(3'd0, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "b2b_first");
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b32.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_done_seen", {31'h0, seen}, 1);
        b32.start = 1'b1; b32.op = 3'd5; b32.rs1_data = 32'hFFFFFFF9; b32.rs2_data = 32'h2;
        q32.push_back('{res: 32'h7FFFFFFC, t0: cyc, lat: 34, name: "b2b_second"});
        @(negedge clk);
        b32.start = 1'b0;
        chk("b2b_busy", b32.busy, 1);
        drain("drain_b2b");

        foreach (v8[i]) begin
            go8(v8[i].op, v8[i].a, v8[i].b, v8[i].r, v8[i].lat, $sformatf("v8_%0d", i));
            drain($sformatf("drain_v8_%0d", i));
        end

        go32(3'd1, 32'h80000000, 32'h80000000, 32'h0, 0, "reset_abort");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", b32.busy, 0);
        chk("rst_mid_done", b32.done, 0);
        chk("rst_mid_result", b32.result, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("final_queue_empty", q32.size() + q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
